vc_mem_responder: RTL and testbench

Memory-side responder for the vc memory request/response protocol. It accepts the request messages that the RISC-V core drives on its instruction and data ports and returns response messages after a fixed, parameterised latency. It holds a word-addressed backing store and performs byte, halfword and word loads and stores. Test harnesses instantiate one per core memory port, so the core's val/rdy request behaviour and its back-to-back fetch and load paths can be exercised at configurable latency.

---
 rtl/vc_mem_responder.sv | 132 +++++++++++++
 tb/tb_vc_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_mem_responder.sv
// Memory-side responder for the vc request/response protocol: word-addressed store with
// byte/halfword/word access and a fixed-latency, in-order response pipeline.
module vc_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [66:0] memreq_msg,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  output logic [34:0] memresp_msg,
  output logic        memresp_val,
  input  logic        stall_in,
  output logic        error
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic          req_type;
  logic [31:0]   req_addr;
  logic [1:0]    req_len;
  logic [31:0]   req_data;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [4:0]    shamt;
  logic          out_of_range;
  logic          misaligned;
  logic          fault;
  logic          accept;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_data;
  logic [31:0]   rsp_data;
  logic [31:0]   base_mask;
  logic [31:0]   wr_mask;
  logic [31:0]   wr_bits;

  logic [LATENCY-1:0] val_q;
  logic [34:0]        msg_q [LATENCY];
  logic               error_q;

  assign req_type = memreq_msg[66];
  assign req_addr = memreq_msg[65:34];
  assign req_len  = memreq_msg[33:32];
  assign req_data = memreq_msg[31:0];

  assign idx          = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign shamt        = {lane, 3'b000};
  assign out_of_range = |req_addr[31:AW+2];

  always_comb begin
    misaligned = 1'b0;
    case (req_len)
      2'd0:    misaligned = (lane != 2'd0);
      2'd1:    misaligned = 1'b0;
      2'd2:    misaligned = lane[0];
      default: misaligned = 1'b1;
    endcase
  end

  assign fault      = out_of_range | misaligned;
  assign memreq_rdy = ~stall_in & ~reset;
  assign accept     = memreq_val & memreq_rdy;

  // Read sees the array before this edge's update; only one request lands per edge.
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> shamt;

  always_comb begin
    rd_data   = rd_word;
    base_mask = 32'hffff_ffff;
    case (req_len)
      2'd1: begin
        rd_data   = {24'b0, rd_shift[7:0]};
        base_mask = 32'h0000_00ff;
      end
      2'd2: begin
        rd_data   = {16'b0, rd_shift[15:0]};
        base_mask = 32'h0000_ffff;
      end
      default: begin
        rd_data   = rd_word;
        base_mask = 32'hffff_ffff;
      end
    endcase
  end

  assign rsp_data = (fault || req_type) ? 32'b0 : rd_data;
  assign wr_mask  = base_mask << shamt;
  assign wr_bits  = req_data << shamt;

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_type && !fault) begin
      mem[idx] <= (mem[idx] & ~wr_mask) | (wr_bits & wr_mask);
    end
  end

  // Message registers load only behind a valid bit so the output holds its last response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        msg_q[i] <= '0;
      end
    end else begin
      val_q[0] <= accept;
      if (accept) begin
        msg_q[0] <= {req_type, req_len, rsp_data};
      end
      for (int i = 1; i < LATENCY; i++) begin
        val_q[i] <= val_q[i-1];
        if (val_q[i-1]) begin
          msg_q[i] <= msg_q[i-1];
        end
      end
      if (accept && fault) begin
        error_q <= 1'b1;
      end
    end
  end

  assign memresp_val = val_q[LATENCY-1];
  assign memresp_msg = msg_q[LATENCY-1];
  assign error       = error_q;

endmodule

// File: tb/tb_vc_mem_responder.sv
// Drives three responders (latency 1, 3, 4) with one request stream and checks each against
// a shared scoreboard of expected responses and their due cycles.
module tb_vc_mem_responder;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [66:0] memreq_msg = '0;
  logic        memreq_val = 1'b0;
  logic        stall_in = 1'b0;

  logic        rdy [3];
  logic [34:0] msg [3];
  logic        val [3];
  logic        err [3];

  int unsigned lat [3] = '{1, 3, 4};

  vc_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(memreq_val),
    .memreq_rdy(rdy[0]), .memresp_msg(msg[0]), .memresp_val(val[0]), .stall_in(stall_in),
    .error(err[0])
  );
  vc_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(memreq_val),
    .memreq_rdy(rdy[1]), .memresp_msg(msg[1]), .memresp_val(val[1]), .stall_in(stall_in),
    .error(err[1])
  );
  vc_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(memreq_val),
    .memreq_rdy(rdy[2]), .memresp_msg(msg[2]), .memresp_val(val[2]), .stall_in(stall_in),
    .error(err[2])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] msg;
    int          acc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mm [int];
  int          head [3] = '{0, 0, 0};
  logic [31:0] last_data [3];
  logic        err_exp = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input int d, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%h expected=%h cyc=%0d", tag, d, obs, expv, cyc);
    end
  endtask

  // Reference model: evaluates each accepted request and pushes its expected response.
  always @(posedge clk) begin
    logic        t;
    logic [31:0] a;
    logic [1:0]  l;
    logic [31:0] dt;
    logic [31:0] rd;
    logic [31:0] cur;
    logic        bad;
    int          w;
    int          n;
    int          ln;
    cyc++;
    if (reset) begin
      err_exp = 1'b0;
    end else if (memreq_val && !stall_in) begin
      t  = memreq_msg[66];
      a  = memreq_msg[65:34];
      l  = memreq_msg[33:32];
      dt = memreq_msg[31:0];
      ln = int'(a % 4);
      bad = (a >= MEM_WORDS * 4) || (l == 2'd3) || (l == 2'd0 && ln != 0) ||
            (l == 2'd2 && a[0]);
      n  = (l == 2'd0) ? 4 : int'(l);
      w  = int'(a / 4);
      rd = '0;
      if (bad) begin
        err_exp = 1'b1;
      end else if (t) begin
        cur = mm.exists(w) ? mm[w] : 32'h0;
        for (int i = 0; i < n; i++) cur[8*(ln+i) +: 8] = dt[8*i +: 8];
        mm[w] = cur;
      end else begin
        cur = mm.exists(w) ? mm[w] : 32'h0;
        for (int i = 0; i < n; i++) rd[8*i +: 8] = cur[8*(ln+i) +: 8];
      end
      exp_q.push_back('{msg: {t, l, rd}, acc: cyc});
    end
  end

  // Monitor: pops expected responses per DUT, checks data, timing and handshake outputs.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk("rdy", d, 64'(rdy[d]), 64'(!stall_in && !reset));
      chk("error", d, 64'(err[d]), 64'(reset ? 1'b0 : err_exp));
      if (reset) begin
        chk("val_in_reset", d, 64'(val[d]), 64'd0);
        head[d] = exp_q.size();
      end else if (val[d]) begin
        if (head[d] < exp_q.size()) begin
          chk("resp_msg", d, 64'(msg[d]), 64'(exp_q[head[d]].msg));
          chk("resp_cycle", d, 64'(cyc), 64'(exp_q[head[d]].acc + int'(lat[d]) - 1));
          last_data[d] = msg[d][31:0];
          head[d]++;
        end else begin
          chk("spurious_val", d, 64'(val[d]), 64'd0);
        end
      end else if (head[d] < exp_q.size() &&
                   cyc >= exp_q[head[d]].acc + int'(lat[d]) - 1) begin
        chk("missing_val", d, 64'(val[d]), 64'd1);
        head[d]++;
      end
    end
  end

  task automatic send(input logic t, input logic [31:0] a, input logic [1:0] l,
                      input logic [31:0] dt);
    memreq_val = 1'b1;
    memreq_msg = {t, a, l, dt};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    memreq_val = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_last(input string tag, input logic [31:0] expv);
    for (int d = 0; d < 3; d++) chk(tag, d, 64'(last_data[d]), 64'(expv));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_val", d, 64'(val[d]), 64'd0);
      chk("reset_msg", d, 64'(msg[d]), 64'd0);
      chk("reset_err", d, 64'(err[d]), 64'd0);
    end
    reset = 1'b0;
    idle(1);

    // Word write then immediate read-after-write.
    send(1'b1, 32'h10, 2'd0, 32'hDEADBEEF);
    send(1'b0, 32'h10, 2'd0, 32'h0);
    idle(5);
    check_last("raw_word", 32'hDEADBEEF);

    // Subword stores and loads.
    send(1'b1, 32'h20, 2'd0, 32'h11223344);
    send(1'b1, 32'h21, 2'd1, 32'h000000AA);
    send(1'b1, 32'h22, 2'd2, 32'h0000BEEF);
    send(1'b0, 32'h20, 2'd0, 32'h0);
    idle(5);
    check_last("lw_merged", 32'hBEEFAA44);
    send(1'b0, 32'h21, 2'd1, 32'h0);
    idle(5);
    check_last("lb_21", 32'h000000AA);
    send(1'b0, 32'h22, 2'd2, 32'h0);
    idle(5);
    check_last("lh_22", 32'h0000BEEF);

    // Back-to-back writes then eight back-to-back reads.
    for (int i = 0; i < 8; i++) send(1'b1, 32'h40 + 32'(4*i), 2'd0, 32'hA5000000 + 32'(i));
    for (int i = 0; i < 8; i++) send(1'b0, 32'h40 + 32'(4*i), 2'd0, 32'h0);
    idle(6);
    check_last("b2b_last", 32'hA5000007);

    // Backpressure with requests in flight.
    send(1'b0, 32'h44, 2'd0, 32'h0);
    send(1'b0, 32'h48, 2'd0, 32'h0);
    stall_in = 1'b1;
    memreq_msg = {1'b0, 32'h4C, 2'd0, 32'h0};
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 3; d++) chk("stall_drained", d, 64'(val[d]), 64'd0);
    stall_in = 1'b0;
    @(posedge clk);
    #1;
    idle(5);
    check_last("stall_release", 32'hA5000003);

    // Misaligned write and out-of-range read.
    send(1'b1, 32'h100, 2'd0, 32'hCAFEF00D);
    send(1'b1, 32'h102, 2'd0, 32'h12345678);
    send(1'b0, 32'h0001_0000, 2'd0, 32'h0);
    idle(5);
    check_last("oor_data", 32'h0);
    for (int d = 0; d < 3; d++) chk("error_sticky", d, 64'(err[d]), 64'd1);
    send(1'b0, 32'h100, 2'd0, 32'h0);
    idle(5);
    check_last("fault_no_write", 32'hCAFEF00D);

    // Reset with reads in flight; memory contents survive.
    send(1'b1, 32'h200, 2'd0, 32'h0BADCAFE);
    idle(5);
    send(1'b0, 32'h200, 2'd0, 32'h0);
    send(1'b0, 32'h10, 2'd0, 32'h0);
    idle(1);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("async_rst_val", d, 64'(val[d]), 64'd0);
      chk("async_rst_msg", d, 64'(msg[d]), 64'd0);
      chk("async_rst_err", d, 64'(err[d]), 64'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    send(1'b0, 32'h200, 2'd0, 32'h0);
    idle(6);
    check_last("persist_after_reset", 32'h0BADCAFE);

    for (int d = 0; d < 3; d++) chk("all_delivered", d, 64'(head[d]), 64'(exp_q.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
